// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding and step count.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/valid handshake bundle for the serial subtractor (operands in, result out).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, valid, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, valid, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: diff = a - b - bin with borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock through chained fs_cell instances.
// Optional build macro SERIAL_SUBTRACTOR_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_diff;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  assign chain[0] = borrow_q;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    fs_cell u_cell (
      .a    (a_sh_q[gi]),
      .b    (b_sh_q[gi]),
      .bin  (chain[gi]),
      .diff (digit_diff[gi]),
      .bout (chain[gi+1])
    );
  end

  // The minuend register doubles as the result register: each finished digit
  // enters at the MSB end as the consumed minuend bits leave at the LSB end.
  if (DIGIT == WIDTH) begin : g_single_step
    assign a_next = digit_diff;
    assign b_next = '0;
  end else begin : g_multi_step
    assign a_next = {digit_diff, a_sh_q[WIDTH-1:DIGIT]};
    assign b_next = {{DIGIT{1'b0}}, b_sh_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_next;
        b_sh_d   = b_next;
        borrow_d = chain[DIGIT];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          bout_d  = chain[DIGIT];
`ifdef SERIAL_SUBTRACTOR_SAT_EN
          diff_d  = chain[DIGIT] ? '0 : a_next;
`else
          diff_d  = a_next;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.valid = (state_q == DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: three configurations (8x1, 8x4, 1x1) sharing clock and reset.
// Honours SERIAL_SUBTRACTOR_SAT_EN when building expected results.
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus81 ();
  serial_subtractor_if #(.WIDTH(8)) bus84 ();
  serial_subtractor_if #(.WIDTH(1)) bus11 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut81 (.clk(clk), .rst_n(rst_n), .bus(bus81));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut84 (.clk(clk), .rst_n(rst_n), .bus(bus84));
  serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut11 (.clk(clk), .rst_n(rst_n), .bus(bus11));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic driveInputs(input int sel, input logic st, input logic [7:0] a,
                             input logic [7:0] b, input logic bin);
    case (sel)
      0:       begin bus81.start = st; bus81.a = a;    bus81.b = b;    bus81.bin = bin; end
      1:       begin bus84.start = st; bus84.a = a;    bus84.b = b;    bus84.bin = bin; end
      default: begin bus11.start = st; bus11.a = a[0]; bus11.b = b[0]; bus11.bin = bin; end
    endcase
  endtask

  task automatic sampleOutputs(input int sel, output logic rdy, output logic bsy, output logic vld,
                               output logic [7:0] dif, output logic bo);
    case (sel)
      0:       begin rdy = bus81.ready; bsy = bus81.busy; vld = bus81.valid; dif = bus81.diff; bo = bus81.bout; end
      1:       begin rdy = bus84.ready; bsy = bus84.busy; vld = bus84.valid; dif = bus84.diff; bo = bus84.bout; end
      default: begin rdy = bus11.ready; bsy = bus11.busy; vld = bus11.valid; dif = {7'b0, bus11.diff}; bo = bus11.bout; end
    endcase
  endtask

  // One full operation from an IDLE negedge: accept, run, check result, return to IDLE.
  task automatic applyStimulus(input string tag, input int sel, input logic [7:0] a, input logic [7:0] b,
                               input logic bin, input logic [7:0] expWrap, input logic expBout,
                               input int steps);
    logic       rdy, bsy, vld, bo;
    logic [7:0] dif, prevDif, expDiff;
    int         n;
    expDiff = (SAT && expBout) ? 8'h00 : expWrap;
    sampleOutputs(sel, rdy, bsy, vld, prevDif, bo);
    checkOutput({tag, ".ready_before"}, {31'b0, rdy}, 32'd1);
    driveInputs(sel, 1'b1, a, b, bin);
    @(posedge clk);
    @(negedge clk);
    driveInputs(sel, 1'b0, ~a, ~b, ~bin);
    sampleOutputs(sel, rdy, bsy, vld, dif, bo);
    checkOutput({tag, ".busy_after_accept"}, {31'b0, bsy}, 32'd1);
    checkOutput({tag, ".diff_held"}, {24'b0, dif}, {24'b0, prevDif});
    n = 0;
    vld = 1'b0;
    while (!vld && n < steps + 4) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      sampleOutputs(sel, rdy, bsy, vld, dif, bo);
    end
    checkOutput({tag, ".latency"}, n, steps);
    checkOutput({tag, ".diff"}, {24'b0, dif}, {24'b0, expDiff});
    checkOutput({tag, ".bout"}, {31'b0, bo}, {31'b0, expBout});
    @(posedge clk);
    @(negedge clk);
    sampleOutputs(sel, rdy, bsy, vld, dif, bo);
    checkOutput({tag, ".valid_single"}, {31'b0, vld}, 32'd0);
    checkOutput({tag, ".ready_after"}, {31'b0, rdy}, 32'd1);
  endtask

  logic [7:0] exp11 [8] = '{8'h0, 8'h1, 8'h1, 8'h0, 8'h1, 8'h0, 8'h0, 8'h1};
  logic       bo11  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic       rdy, bsy, vld, bo;
    logic [7:0] dif;
    int         vcount;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) driveInputs(s, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sampleOutputs(s, rdy, bsy, vld, dif, bo);
      checkOutput($sformatf("reset%0d.ready", s), {31'b0, rdy}, 32'd1);
      checkOutput($sformatf("reset%0d.busy", s),  {31'b0, bsy}, 32'd0);
      checkOutput($sformatf("reset%0d.valid", s), {31'b0, vld}, 32'd0);
      checkOutput($sformatf("reset%0d.diff", s),  {24'b0, dif}, 32'd0);
      checkOutput($sformatf("reset%0d.bout", s),  {31'b0, bo},  32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("w8d1_100_37", 0, 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 8);
    applyStimulus("w8d1_5_9",    0, 8'd5,   8'd9,  1'b0, 8'hFC, 1'b1, 8);

    // start held high with operands churning: only the first IDLE cycle restarts
    driveInputs(0, 1'b1, 8'd100, 8'd37, 1'b0);
    @(posedge clk);
    vcount = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sampleOutputs(0, rdy, bsy, vld, dif, bo);
      vcount += int'(vld);
      driveInputs(0, 1'b1, 8'(k * 29), 8'(k * 71), k[0]);
      @(posedge clk);
    end
    @(negedge clk);
    sampleOutputs(0, rdy, bsy, vld, dif, bo);
    checkOutput("hold.no_early_valid", vcount, 0);
    checkOutput("hold.valid1", {31'b0, vld}, 32'd1);
    checkOutput("hold.diff1", {24'b0, dif}, 32'd63);
    checkOutput("hold.ready_in_done", {31'b0, rdy}, 32'd0);
    driveInputs(0, 1'b1, 8'd200, 8'd50, 1'b0);
    @(posedge clk);
    @(negedge clk);
    sampleOutputs(0, rdy, bsy, vld, dif, bo);
    checkOutput("hold.ready_idle", {31'b0, rdy}, 32'd1);
    checkOutput("hold.valid_low", {31'b0, vld}, 32'd0);
    vcount = 0;
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk);
      @(negedge clk);
      driveInputs(0, 1'b1, 8'hFF, 8'h01, 1'b1);
      sampleOutputs(0, rdy, bsy, vld, dif, bo);
      if (j < 9) vcount += int'(vld);
      if (j == 8) checkOutput("hold.diff_stable", {24'b0, dif}, 32'd63);
    end
    driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("hold.no_valid_run2", vcount, 0);
    checkOutput("hold.valid2", {31'b0, vld}, 32'd1);
    checkOutput("hold.diff2", {24'b0, dif}, 32'd150);
    @(posedge clk);
    @(negedge clk);

    applyStimulus("w8d4_a5_5a", 1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 2);
    applyStimulus("w8d4_0_0_1", 1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 2);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      applyStimulus($sformatf("w1d1_%0d", i), 2, {7'b0, v[2]}, {7'b0, v[1]}, v[0],
                    exp11[i], bo11[i], 1);
    end

    // abort mid-run: reset after RUN edge 3 of the 8x1 unit
    driveInputs(0, 1'b1, 8'd100, 8'd37, 1'b0);
    @(posedge clk);
    @(negedge clk);
    driveInputs(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sampleOutputs(0, rdy, bsy, vld, dif, bo);
    checkOutput("abort.ready", {31'b0, rdy}, 32'd1);
    checkOutput("abort.busy",  {31'b0, bsy}, 32'd0);
    checkOutput("abort.valid", {31'b0, vld}, 32'd0);
    checkOutput("abort.diff",  {24'b0, dif}, 32'd0);
    checkOutput("abort.bout",  {31'b0, bo},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      sampleOutputs(0, rdy, bsy, vld, dif, bo);
      vcount += int'(vld);
    end
    checkOutput("abort.no_valid", vcount, 0);
    applyStimulus("post_abort_5_9", 0, 8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised, multi-cycle N-bit subtractor: computes `diff = a - b - bin` by processing `DIGIT` bits per clock through a chain of full-subtractor cells, with borrow carried across cycles. It succeeds the single-bit full-subtractor cell as the arithmetic building block for datapaths that trade latency for area. It uses a start/ready/valid handshake and holds its result until the next operation.

## Interface
- `WIDTH`, 8, operand/result width in bits; ≥ 1.
- `DIGIT`, 1, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `a`  in  WIDTH  minuend, captured on the accepting edge.
- `b`  in  WIDTH  subtrahend, captured on the accepting edge.
- `bin`  in  1  borrow-in, captured on the accepting edge.
- `ready`  out  1  block idle, can accept `start`.
- `busy`  out  1  operation in progress; equals `!ready`.
- `valid`  out  1  one-cycle pulse: `diff`/`bout` just updated.
- `diff`  out  WIDTH  result register.
- `bout`  out  1  final borrow-out; 1 when `a < b + bin`.

## Operation
- STEPS = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`=1, capture `a`, `b`, `bin` into shift registers, clear step counter, go to RUN.
- RUN: each edge, subtract the low DIGIT bits of the shift registers with the running borrow through DIGIT chained cells. Shift the partial difference in at the MSB end and update the borrow. Increment the counter. On the STEPS-th RUN edge, load `diff`/`bout` from the completed result and go to DONE.
- DONE: `valid`=1 for exactly this cycle; the next edge returns to IDLE.
- `start` is ignored in RUN and DONE; no queuing.
- `diff`/`bout` change only on the load edge; they hold their value through later operations until the next load.
- Arithmetic is modulo 2^WIDTH two's-complement wrap. `bout` is the borrow out of the MSB.

## Timing
- Reset (async assert, sync release): state IDLE, `ready`=1, `busy`=0, `valid`=0, `diff`=0, `bout`=0, counter and shift registers 0.
- Latency:
  - `start` accepted at edge 0; RUN covers edges 1..STEPS.
  - `valid` is high in the cycle after edge STEPS.
  - `ready` returns high after edge STEPS+1.
- Throughput: one operation per STEPS+2 cycles. `start` held high continuously restarts at the first IDLE cycle.
- Reset asserted mid-RUN/DONE aborts immediately. All outputs take reset values in the same cycle; no `valid` is produced.
- Operand inputs may change freely after the accepting edge.

## Configuration
- `SERIAL_SUBTRACTOR_SAT_EN` defined: on the load edge, if the final borrow is 1, `diff` loads 0 (saturate at zero). `bout` still reports 1.
- Not defined: `diff` loads the wrapped result.
- Latency and handshake are identical in both builds.

## Structure
- Package `serial_subtractor_pkg`: state enum type (IDLE/RUN/DONE) and a function computing STEPS from WIDTH and DIGIT.
- Sub-module `fs_cell`: 1-bit full subtractor.
  - Ports: `a`, `b`, `bin`, `diff`, `bout`.
  - `diff = a^b^bin`; `bout = (~a&b) | (~(a^b)&bin)`.
  - Instantiated DIGIT times in a generate loop with the borrow rippled between cells.

## Test plan
- WIDTH=8, DIGIT=1; a=100, b=37, bin=0 → `diff`=63, `bout`=0, `valid` in the cycle after edge 8, single pulse.
- WIDTH=8, DIGIT=1; a=5, b=9, bin=0 → `diff`=8'hFC, `bout`=1. With SAT_EN: `diff`=8'h00, `bout`=1.
- WIDTH=8, DIGIT=4; a=8'hA5, b=8'h5A, bin=0 → `diff`=8'h4B, `bout`=0, `valid` in the cycle after edge 2. Then a=0, b=0, bin=1 → `diff`=8'hFF, `bout`=1.
- WIDTH=1, DIGIT=1, exhaustive: all 8 {a,b,bin} combinations back-to-back → (diff,bout) = 00,11,11,01,10,00,00,11 (no SAT_EN).
- `start` held high and operands toggled during RUN/DONE → no restart until `ready`. `diff` stable until its load edge. Exactly one `valid` per accepted `start`.
- `rst_n` pulsed low at RUN step 3 (WIDTH=8, DIGIT=1) → outputs 0 and `ready`=1 immediately. No `valid`. The next `start` computes correctly.
